// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared state encoding and Booth pair decode for booth_mult_seq
package booth_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } booth_state_t;

    // {Q[0], qm1} pairs that trigger an add or subtract of M
    localparam logic [1:0] BOOTH_SUB = 2'b10;
    localparam logic [1:0] BOOTH_ADD = 2'b01;

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one radix-2 Booth iteration: add/sub of M then arithmetic right shift
module booth_step
    import booth_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W+1:0] acc,
    input  logic [W:0]   q,
    input  logic         qm1,
    input  logic [W:0]   m,
    output logic [W+1:0] acc_next,
    output logic [W:0]   q_next,
    output logic         qm1_next
);

    logic [W+1:0] m_ext;
    logic [W+1:0] sum;

    assign m_ext = {m[W], m};

    always_comb begin
        sum = acc;
        case ({q[0], qm1})
            BOOTH_SUB: sum = acc - m_ext;
            BOOTH_ADD: sum = acc + m_ext;
            default:   sum = acc;
        endcase
    end

    assign acc_next = {sum[W+1], sum[W+1:1]};
    assign q_next   = {sum[0], q[W:1]};
    assign qm1_next = q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier, signed/unsigned; BOOTH_BUSY_ERR_EN adds busy_err
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   product
`ifdef BOOTH_BUSY_ERR_EN
    ,
    output logic             busy_err
`endif
);

    localparam int CW = $clog2(W + 2);
    localparam logic [CW-1:0] ITERS = CW'(W + 1);

    booth_state_t  state;
    logic [W+1:0]  acc;
    logic [W:0]    q;
    logic [W:0]    m;
    logic          qm1;
    logic [CW-1:0] count;

    logic [W+1:0]  acc_n;
    logic [W:0]    q_n;
    logic          qm1_n;

    booth_step #(.W(W)) u_step (
        .acc      (acc),
        .q        (q),
        .qm1      (qm1),
        .m        (m),
        .acc_next (acc_n),
        .q_next   (q_n),
        .qm1_next (qm1_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            q         <= '0;
            m         <= '0;
            qm1       <= 1'b0;
            count     <= '0;
            ready     <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // one extra bit lets unsigned operands ride the signed datapath
                        acc   <= '0;
                        m     <= {sgn & a[W-1], a};
                        q     <= {sgn & b[W-1], b};
                        qm1   <= 1'b0;
                        count <= ITERS;
                        ready <= 1'b0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc   <= acc_n;
                    q     <= q_n;
                    qm1   <= qm1_n;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        product   <= {acc_n[W-2:0], q_n};
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ready     <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    ready     <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BOOTH_BUSY_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_err <= 1'b0;
        end else begin
            busy_err <= start && !ready;
        end
    end
`endif

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - self-checking bench for booth_mult_seq (W=16 directed, W=4/8 sweep)
module tb_booth_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy_err;

    int tests = 0;
    int fails = 0;
    bit dir_done = 1'b0;
    int sweep_done_cnt = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(.W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sgn       (sgn),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
`ifdef BOOTH_BUSY_ERR_EN
        ,
        .busy_err  (busy_err)
`endif
    );

`ifndef BOOTH_BUSY_ERR_EN
    assign busy_err = 1'b0;
`endif

    function automatic logic [31:0] ref_mul(input logic s, input logic [15:0] x, input logic [15:0] y);
        longint sx;
        longint sy;
        sx = s ? longint'($signed(x)) : longint'(x);
        sy = s ? longint'($signed(y)) : longint'(y);
        return 32'(sx * sy);
    endfunction

    // transaction-level model: pending request, edges since acceptance, expected product
    bit          m_live = 1'b0;
    bit          m_pending = 1'b0;
    int          m_elapsed = 0;
    logic [31:0] m_exp = '0;
    bit          m_busy = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_live    <= 1'b1;
            m_pending <= 1'b0;
            m_elapsed <= 0;
            m_busy    <= 1'b0;
        end else begin
            m_busy <= start && m_pending;
            if (!m_pending) begin
                if (start) begin
                    m_pending <= 1'b1;
                    m_elapsed <= 0;
                    m_exp     <= ref_mul(sgn, a, b);
                end
            end else if (m_elapsed >= 17) begin
                if (out_ready) m_pending <= 1'b0;
            end else begin
                m_elapsed <= m_elapsed + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live && !rst) begin
            tests++;
            if (ready !== !m_pending) begin
                fails++;
                $display("FAIL cmp_ready: got %b want %b at %0t", ready, !m_pending, $time);
            end
            tests++;
            if (out_valid !== (m_pending && m_elapsed >= 17)) begin
                fails++;
                $display("FAIL cmp_out_valid: got %b want %b at %0t", out_valid, (m_pending && m_elapsed >= 17), $time);
            end
            if (m_pending && m_elapsed >= 17) begin
                tests++;
                if (product !== m_exp) begin
                    fails++;
                    $display("FAIL cmp_product: got %h want %h at %0t", product, m_exp, $time);
                end
            end
`ifdef BOOTH_BUSY_ERR_EN
            tests++;
            if (busy_err !== m_busy) begin
                fails++;
                $display("FAIL cmp_busy_err: got %b want %b at %0t", busy_err, m_busy, $time);
            end
`endif
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // accept a request and wait for out_valid; leaves the result pending
    task automatic issue(input string name, input logic s, input logic [15:0] x, input logic [15:0] y,
                         input logic [31:0] lit, input logic hold_ready);
        int lat;
        @(posedge clk); #1;
        sgn = s; a = x; b = y; start = 1'b1; out_ready = hold_ready;
        @(posedge clk); #1;
        start = 1'b0; a = 16'($urandom); b = 16'($urandom); sgn = ~s;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd17);
        check({name, "_product"}, product, lit);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input string name, input logic s, input logic [15:0] x, input logic [15:0] y,
                       input logic [31:0] lit);
        issue(name, s, x, y, lit, 1'b0);
        release_result();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_product", product, 32'd0);
        rst = 1'b0;

        run("t1_signed", 1'b1, 16'h8006, 16'h000D, 32'hFFF9_804E);
        issue("t2_unsigned", 1'b0, 16'h8006, 16'h000D, 32'h0006_804E, 1'b1);
        release_result();
        run("t3_signed_ffff", 1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001);
        run("t3_unsigned_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        run("t4_min_min", 1'b1, 16'h8000, 16'h8000, 32'h4000_0000);
        run("t4_a_zero", 1'b1, 16'h0000, 16'h1234, 32'h0000_0000);
        run("t4_b_zero", 1'b0, 16'hBEEF, 16'h0000, 32'h0000_0000);
        run("t4_unsigned_min", 1'b0, 16'h8000, 16'h8000, 32'h4000_0000);

        issue("t5_stall", 1'b1, 16'h0123, 16'hFF00, 32'hFFFE_DD00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            start = i[0]; a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            check("t5_hold_product", product, 32'hFFFE_DD00);
            check("t5_hold_valid", 32'(out_valid), 32'd1);
            check("t5_hold_ready", 32'(ready), 32'd0);
        end
        start = 1'b0;
        release_result();

        @(posedge clk); #1;
        sgn = 1'b1; a = 16'h7FFF; b = 16'h7FFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_rst_ready", 32'(ready), 32'd1);
        check("t6_rst_out_valid", 32'(out_valid), 32'd0);
        run("t6_after_rst", 1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001);
        run("t6_mixed", 1'b1, 16'hFFFE, 16'h0003, 32'hFFFF_FFFA);

        dir_done = 1'b1;
        for (int c = 0; c < 20000 && sweep_done_cnt < 2; c++) @(posedge clk);
        tests++;
        if (sweep_done_cnt < 2) begin
            fails++;
            $display("FAIL sweep_timeout: got %0d want 2", sweep_done_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
        localparam int GW = (gi == 0) ? 4 : 8;
        logic            gstart;
        logic            gsgn;
        logic [GW-1:0]   ga;
        logic [GW-1:0]   gb;
        logic            gready;
        logic            gout_valid;
        logic            gout_ready;
        logic [2*GW-1:0] gproduct;
        logic            gbusy_err;

        booth_mult_seq #(.W(GW)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (gstart),
            .sgn       (gsgn),
            .a         (ga),
            .b         (gb),
            .ready     (gready),
            .out_valid (gout_valid),
            .out_ready (gout_ready),
            .product   (gproduct)
`ifdef BOOTH_BUSY_ERR_EN
            ,
            .busy_err  (gbusy_err)
`endif
        );

`ifndef BOOTH_BUSY_ERR_EN
        assign gbusy_err = 1'b0;
`endif

        initial begin
            logic [2*GW-1:0] exp;
            longint sa;
            longint sb;
            int lat;
            gstart = 1'b0; gsgn = 1'b0; ga = '0; gb = '0; gout_ready = 1'b0;
            wait (dir_done);
            for (int n = 0; n < 48; n++) begin
                @(posedge clk); #1;
                ga = GW'($urandom); gb = GW'($urandom); gsgn = n[0];
                if (n < 4) begin
                    ga = {1'b1, {(GW-1){1'b0}}};
                    gb = n[1] ? {GW{1'b1}} : {1'b1, {(GW-1){1'b0}}};
                end
                sa = gsgn ? longint'($signed(ga)) : longint'(ga);
                sb = gsgn ? longint'($signed(gb)) : longint'(gb);
                exp = (2*GW)'(sa * sb);
                gstart = 1'b1;
                @(posedge clk); #1;
                gstart = 1'b0;
                lat = 0;
                while (!gout_valid && lat < 3 * GW + 10) begin
                    @(posedge clk); #1;
                    lat++;
                end
                tests++;
                if (lat != GW + 1) begin
                    fails++;
                    $display("FAIL sweep_w%0d_latency: got %0d want %0d", GW, lat, GW + 1);
                end
                tests++;
                if (gout_valid !== 1'b1 || gproduct !== exp) begin
                    fails++;
                    $display("FAIL sweep_w%0d_product: a=%h b=%h sgn=%b got %h want %h",
                             GW, ga, gb, gsgn, gproduct, exp);
                end
                gout_ready = 1'b1;
                @(posedge clk); #1;
                gout_ready = 1'b0;
            end
            sweep_done_cnt++;
        end
    end

endmodule
